gf2_digit_serial_mult: RTL and testbench



---
 rtl/gf2_digit_serial_mult.sv | 165 ++++++++++++++++
 tb/tb_gf2_digit_serial_mult.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf2_digit_serial_mult.sv
// Digit-serial carry-less (GF(2)[x]) multiplier: consumes LANES digits of A per cycle,
// MSB-first, Horner-accumulating into an unreduced 2*WIDTH-bit product with optional MAC.
module gf2_digit_serial_mult #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 8,
    parameter int LANES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mac,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int GRP   = DIGIT * LANES;
    localparam int NSTEP = WIDTH / GRP;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int PPW   = WIDTH + DIGIT - 1;
    localparam int RW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

    if (WIDTH % GRP != 0) begin : g_bad_width
        $error("gf2_digit_serial_mult: WIDTH must be a multiple of DIGIT*LANES");
    end
    if (DIGIT != 2 && DIGIT != 4 && DIGIT != 8) begin : g_bad_digit
        $error("gf2_digit_serial_mult: DIGIT must be 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   a_r, a_s;
    logic [WIDTH-1:0]   b_r, b_s;
    logic               mac_r, mac_s;
    logic [RW-1:0]      acc_r, acc_s;
    logic [RW-1:0]      result_r, result_s;
    logic               out_valid_r, out_valid_s;
    logic               busy_r, busy_s;
    logic               in_ready_r, in_ready_s;
    logic [GRP-1:0]     grp_s;
    logic [RW-1:0]      step_acc_s;

    // Carry-less product of one digit with the full B operand.
    function automatic logic [PPW-1:0] clmul_digit(input logic [DIGIT-1:0] d,
                                                   input logic [WIDTH-1:0] b);
        logic [PPW-1:0] p;
        p = {PPW{1'b0}};
        for (int i = 0; i < DIGIT; i++) begin
            p = p ^ (({{(DIGIT-1){1'b0}}, b} << i) & {PPW{d[i]}});
        end
        return p;
    endfunction

    // One Horner step: shift the accumulator by a digit group and fold in all lane products.
    always_comb begin
        grp_s      = a_r[WIDTH-1 -: GRP];
        step_acc_s = acc_r << GRP;
        for (int l = 0; l < LANES; l++) begin
            step_acc_s = step_acc_s ^
                (RW'(clmul_digit(grp_s[GRP-1-l*DIGIT -: DIGIT], b_r)) << (DIGIT * (LANES - 1 - l)));
        end
    end

    // Next-state and next-output logic; A is consumed by shifting the processed group out the top.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        a_s         = a_r;
        b_s         = b_r;
        mac_s       = mac_r;
        acc_s       = acc_r;
        result_s    = result_r;
        out_valid_s = out_valid_r;
        busy_s      = busy_r;
        in_ready_s  = in_ready_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    a_s        = in_a;
                    b_s        = in_b;
                    mac_s      = in_mac;
                    acc_s      = {RW{1'b0}};
                    cnt_s      = {CNT_W{1'b0}};
                    state_s    = ST_BUSY;
                    in_ready_s = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    in_ready_s = 1'b1;
                end
            end
            ST_BUSY: begin
                acc_s = step_acc_s;
                a_s   = a_r << GRP;
                cnt_s = cnt_r + CNT_W'(1'b1);
                if (cnt_r == CNT_LAST) begin
                    result_s    = step_acc_s ^ (mac_r ? result_r : {RW{1'b0}});
                    out_valid_s = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    in_ready_s  = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                out_valid_s = 1'b0;
                busy_s      = 1'b0;
                in_ready_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            mac_r       <= 1'b0;
            acc_r       <= {RW{1'b0}};
            result_r    <= {RW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            a_r         <= a_s;
            b_r         <= b_s;
            mac_r       <= mac_s;
            acc_r       <= acc_s;
            result_r    <= result_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
            in_ready_r  <= in_ready_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;

endmodule

// File: tb/tb_gf2_digit_serial_mult.sv
// Bench for gf2_digit_serial_mult: four configurations checked every cycle against a
// transaction-level clmul model, plus directed literal checks on the default configuration.
module tb_gf2_digit_serial_mult;

    localparam int NST [4] = '{4, 8, 4, 8};
    localparam int WID [4] = '{64, 64, 64, 32};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n    [4];
    logic        in_valid [4];
    logic        in_mac   [4];
    logic [63:0] in_a     [4];
    logic [63:0] in_b     [4];
    logic        or_dir   [4];
    logic        or_rand  [4];
    logic        rand_or  [4];
    logic        out_ready[4];
    logic        in_ready_w [4];
    logic        busy_w     [4];
    logic        out_valid_w[4];
    logic [127:0] result_w  [4];
    logic [127:0] res0, res1, res2;
    logic [63:0]  res3;

    int n_cmp = 0;
    int n_bad = 0;

    always_comb begin
        for (int k = 0; k < 4; k++) out_ready[k] = rand_or[k] ? or_rand[k] : or_dir[k];
        result_w[0] = res0;
        result_w[1] = res1;
        result_w[2] = res2;
        result_w[3] = {64'd0, res3};
    end

    gf2_digit_serial_mult #(.WIDTH(64), .DIGIT(8), .LANES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_mac(in_mac[0]), .busy(busy_w[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready[0]), .result(res0));
    gf2_digit_serial_mult #(.WIDTH(64), .DIGIT(8), .LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_mac(in_mac[1]), .busy(busy_w[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready[1]), .result(res1));
    gf2_digit_serial_mult #(.WIDTH(64), .DIGIT(4), .LANES(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_mac(in_mac[2]), .busy(busy_w[2]),
        .out_valid(out_valid_w[2]), .out_ready(out_ready[2]), .result(res2));
    gf2_digit_serial_mult #(.WIDTH(32), .DIGIT(2), .LANES(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n[3]), .in_valid(in_valid[3]), .in_ready(in_ready_w[3]),
        .in_a(in_a[3][31:0]), .in_b(in_b[3][31:0]), .in_mac(in_mac[3]), .busy(busy_w[3]),
        .out_valid(out_valid_w[3]), .out_ready(out_ready[3]), .result(res3));

    function automatic logic [63:0] msk(input int i);
        return (WID[i] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << WID[i]) - 64'd1);
    endfunction

    // Plain bit-by-bit polynomial product.
    function automatic logic [127:0] clmul_ref(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        p = 128'd0;
        for (int i = 0; i < 64; i++) if (a[i]) p = p ^ ({64'd0, b} << i);
        return p;
    endfunction

    task automatic chk(input string nm, input int i, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", nm, i, $time, act, exp);
        end
    endtask

    // Transaction-level model: ready flag, remaining-step countdown, expected result.
    logic         m_rdy  [4];
    logic         m_ov   [4];
    logic         m_mac  [4];
    logic         acc_evt[4];
    int           m_left [4];
    logic [127:0] m_res  [4];
    logic [127:0] m_prod [4];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            acc_evt[i] = 1'b0;
            if (!rst_n[i]) begin
                m_rdy[i] = 1'b0; m_ov[i] = 1'b0; m_left[i] = 0; m_res[i] = 128'd0;
            end else if (m_ov[i]) begin
                if (out_ready[i]) begin m_ov[i] = 1'b0; m_rdy[i] = 1'b1; end
            end else if (m_left[i] > 0) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_ov[i]  = 1'b1;
                    m_res[i] = m_prod[i] ^ (m_mac[i] ? m_res[i] : 128'd0);
                end
            end else if (in_valid[i] && m_rdy[i]) begin
                acc_evt[i] = 1'b1;
                m_rdy[i]   = 1'b0;
                m_left[i]  = NST[i];
                m_prod[i]  = clmul_ref(in_a[i] & msk(i), in_b[i] & msk(i));
                m_mac[i]   = in_mac[i];
            end else begin
                m_rdy[i] = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            chk("in_ready",  i, 128'(in_ready_w[i]),  128'(m_rdy[i]));
            chk("busy",      i, 128'(busy_w[i]),      128'(m_left[i] > 0));
            chk("out_valid", i, 128'(out_valid_w[i]), 128'(m_ov[i]));
            chk("result",    i, result_w[i],          m_res[i]);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) or_rand[k] = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int i, input logic [63:0] a, input logic [63:0] b, input logic mac);
        int got;
        got = 0;
        @(negedge clk);
        in_a[i] = a & msk(i); in_b[i] = b & msk(i); in_mac[i] = mac; in_valid[i] = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1;
            if (acc_evt[i]) begin got = 1; break; end
        end
        in_valid[i] = 1'b0;
        chk("accept", i, 128'(got), 128'd1);
    endtask

    task automatic wait_done(input int i, output int lat, output int nb);
        lat = 0; nb = 0;
        for (int t = 0; t < 60; t++) begin
            if (out_valid_w[i]) break;
            if (busy_w[i]) nb++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op0(input logic [63:0] a, input logic [63:0] b, input logic mac,
                       input logic [127:0] exp, input string nm);
        int lat, nb;
        send(0, a, b, mac);
        wait_done(0, lat, nb);
        chk({nm, "_lat"}, 0, 128'(lat), 128'd4);
        chk({nm, "_busy_cycles"}, 0, 128'(nb), 128'd4);
        chk(nm, 0, result_w[0], exp);
        @(posedge clk); #1;
    endtask

    task automatic rand_ops(input int i, input int n);
        logic [63:0] a, b;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (k % 25 == 0) a = 64'd0;
            if (k % 25 == 1) b = 64'hFFFF_FFFF_FFFF_FFFF;
            send(i, a, b, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat, nb;
        for (int k = 0; k < 4; k++) begin
            rst_n[k] = 1'b0; in_valid[k] = 1'b0; in_mac[k] = 1'b0;
            in_a[k] = 64'd0; in_b[k] = 64'd0; or_dir[k] = 1'b1; rand_or[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_in_ready", k, 128'(in_ready_w[k]), 128'd0);
            chk("rst_out_valid", k, 128'(out_valid_w[k]), 128'd0);
            chk("rst_result", k, result_w[k], 128'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) rst_n[k] = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) chk("first_ready", k, 128'(in_ready_w[k]), 128'd1);

        op0(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, "ones");
        op0(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 128'd1 << 126, "top_bits");
        op0(64'h3, 64'h3, 1'b0, 128'h5, "three_sq");
        op0(64'h2, 64'h2, 1'b1, 128'h1, "mac_chain");
        op0(64'h0, 64'h1234, 1'b0, 128'h0, "zero_a");

        // Backpressure: result held, new operands refused until the handshake.
        or_dir[0] = 1'b0;
        send(0, 64'h3, 64'h3, 1'b0);
        wait_done(0, lat, nb);
        chk("bp_lat", 0, 128'(lat), 128'd4);
        @(negedge clk);
        in_a[0] = 64'h2; in_b[0] = 64'h2; in_mac[0] = 1'b0; in_valid[0] = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            chk("bp_ready", 0, 128'(in_ready_w[0]), 128'd0);
            chk("bp_valid", 0, 128'(out_valid_w[0]), 128'd1);
            chk("bp_result", 0, result_w[0], 128'h5);
        end
        @(negedge clk);
        or_dir[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 0, 128'(out_valid_w[0]), 128'd0);
        chk("bp_release_ready", 0, 128'(in_ready_w[0]), 128'd1);
        @(posedge clk); #1;
        chk("bp_next_accept", 0, 128'(busy_w[0]), 128'd1);
        in_valid[0] = 1'b0;
        wait_done(0, lat, nb);
        chk("bp_next_result", 0, result_w[0], 128'h4);
        @(posedge clk); #1;

        // Reset in the middle of an operation.
        send(0, 64'h0123_4567_89AB_CDEF, 64'h1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 0, 128'(out_valid_w[0]), 128'd0);
        chk("midrst_busy", 0, 128'(busy_w[0]), 128'd0);
        chk("midrst_result", 0, result_w[0], 128'd0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready", 0, 128'(in_ready_w[0]), 128'd1);
        chk("midrst_result2", 0, result_w[0], 128'd0);
        op0(64'h0123_4567_89AB_CDEF, 64'h1, 1'b0, 128'h0000_0000_0000_0000_0123_4567_89AB_CDEF, "rerun");

        for (int k = 0; k < 4; k++) rand_or[k] = 1'b1;
        fork
            rand_ops(0, 200);
            rand_ops(1, 200);
            rand_ops(2, 200);
            rand_ops(3, 200);
        join
        for (int k = 0; k < 4; k++) rand_or[k] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
